// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified instruction/data memory between the CPU and the external loader/debug port.
// Latency: grant in IDLE, N ACCESS cycles, done pulse in RESP (3 cycles minimum per access).
// Backpressure: requesters hold req until done; CPU is stalled meanwhile; memory waits are bounded by TIMEOUT.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset_n,

    // CPU port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,

    // External loader/debug port
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_done,

    // Completion status shared by both ports
    output logic          err,

    // Memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Streak counter must be able to hold MAX_STREAK itself; wait counter only needs 0..TIMEOUT-1.
    localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_CAP = SW'(MAX_STREAK);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;

    // Latched access descriptor; owner_ext=0 means the CPU owns the access.
    logic          owner_ext;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ext_rdata_q;
    logic          err_q;

    logic [SW-1:0] streak_q;
    logic [WW-1:0] wait_q;

    logic          any_req;
    logic          grant_ext;
    logic          timed_out;
    logic          acc_end;

    // Winner selection and access termination decode.
    always_comb begin
        any_req   = cpu_req | ext_req;
        // CPU has priority until it has won MAX_STREAK times in a row over a waiting ext request.
        grant_ext = ext_req & (~cpu_req | (streak_q == STREAK_CAP));
        // mem_ready takes precedence over a timeout landing in the same cycle.
        timed_out = (wait_q == WAIT_LAST) & ~mem_ready;
        acc_end   = mem_ready | timed_out;
    end

    // State register; reset drops straight to IDLE, abandoning any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_done  = 1'b0;
        ext_done  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (acc_end) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Requests are deliberately not looked at here, so a held req cannot double-grant.
                cpu_done  = ~owner_ext;
                ext_done  = owner_ext;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's operands at grant so the memory sees them stable for all of ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_ext <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (state == IDLE && any_req) begin
            owner_ext <= grant_ext;
            we_q      <= grant_ext ? ext_we    : cpu_we;
            addr_q    <= grant_ext ? ext_addr  : cpu_addr;
            wdata_q   <= grant_ext ? ext_wdata : cpu_wdata;
        end
    end

    // Anti-starvation streak: counts CPU wins over a waiting ext request, saturating at MAX_STREAK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else if (state == IDLE) begin
            if (!ext_req || grant_ext) begin
                streak_q <= '0;
            end else if (cpu_req && streak_q != STREAK_CAP) begin
                streak_q <= streak_q + SW'(1);
            end
        end
    end

    // Memory wait counter: runs through ACCESS, held at zero elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else if (state == ACCESS) begin
            wait_q <= wait_q + WW'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Capture completion status and read data for the owning port at the end of ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else if (state == ACCESS && acc_end) begin
            err_q <= timed_out;
            if (mem_ready) begin
                // Writes leave the owner's rdata untouched.
                if (!we_q) begin
                    if (owner_ext) begin
                        ext_rdata_q <= mem_rdata;
                    end else begin
                        cpu_rdata_q <= mem_rdata;
                    end
                end
            end else begin
                // Timed-out access returns zero so stale data is never mistaken for a result.
                if (owner_ext) begin
                    ext_rdata_q <= '0;
                end else begin
                    cpu_rdata_q <= '0;
                end
            end
        end else begin
            // err is only meaningful alongside the done pulse in RESP.
            err_q <= 1'b0;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign err       = err_q;

    // Combinational so the CPU path controller freezes PC/IR in the same cycle it requests.
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_done, cpu_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          ext_done, err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_done(ext_done), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        bit          is_ext;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        bit          is_ext;
        bit          err;
        logic [31:0] rdata;
    } done_t;

    acc_t        exp_acc[$];
    done_t       exp_done[$];
    logic [31:0] model [logic [31:0]];

    int n_tests;
    int n_fail;
    int cyc;
    int mem_lat;
    bit mem_stuck;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Memory responder: ready after mem_lat extra ACCESS cycles, never when stuck.
    initial begin
        int acc_cnt;
        acc_cnt   = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (!mem_stuck && acc_cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    if (mem_we) model[mem_addr] = mem_wdata;
                    else mem_rdata = model.exists(mem_addr) ? model[mem_addr] : 32'h0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                acc_cnt++;
            end else begin
                mem_ready = 1'b0;
                acc_cnt   = 0;
            end
        end
    end

    // Scoreboard monitor: grants and completions are checked against the expected queues.
    initial begin
        acc_t        a;
        done_t       d;
        bit          prev_en;
        logic [31:0] s_addr, s_wdata, got;
        logic        s_we;
        prev_en = 1'b0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_en = 1'b0;
            end else begin
                if (mem_en && !prev_en) begin
                    n_tests++;
                    if (exp_acc.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_grant: unexpected access addr=%h we=%b", mem_addr, mem_we);
                    end else begin
                        a = exp_acc.pop_front();
                        if (mem_addr !== a.addr || mem_we !== a.we || (a.we && mem_wdata !== a.wdata)) begin
                            n_fail++;
                            $display("FAIL mon_grant: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                                     mem_addr, mem_we, mem_wdata, a.addr, a.we, a.wdata);
                        end
                    end
                    s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
                end else if (mem_en) begin
                    n_tests++;
                    if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
                        n_fail++;
                        $display("FAIL mon_stable: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wdata);
                    end
                end
                if (cpu_done || ext_done) begin
                    n_tests++;
                    if (cpu_done && ext_done) begin
                        n_fail++;
                        $display("FAIL mon_done: both done pulses high, want exactly one");
                    end else if (exp_done.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_done: unexpected done cpu=%b ext=%b", cpu_done, ext_done);
                    end else begin
                        d   = exp_done.pop_front();
                        got = ext_done ? ext_rdata : cpu_rdata;
                        if (ext_done !== d.is_ext || err !== d.err || got !== d.rdata) begin
                            n_fail++;
                            $display("FAIL mon_done: got ext=%b err=%b rdata=%h, want ext=%b err=%b rdata=%h",
                                     ext_done, err, got, d.is_ext, d.err, d.rdata);
                        end
                    end
                end
                prev_en = mem_en;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            ext_req   = 1'($urandom_range(0, 1));
            ext_we    = 1'($urandom_range(0, 1));
            ext_addr  = $urandom;
            ext_wdata = $urandom;
            #1;
            n_tests++;
            if ({cpu_done, ext_done, err, mem_en, mem_we} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl: got done/done/err/en/we=%b, want 00000",
                         {cpu_done, ext_done, err, mem_en, mem_we});
            end
            n_tests++;
            if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data: got crd=%h erd=%h addr=%h wd=%h, want all 0",
                         cpu_rdata, ext_rdata, mem_addr, mem_wdata);
            end
            n_tests++;
            if (cpu_stall !== cpu_req) begin
                n_fail++;
                $display("FAIL reset_stall: got %b want %b", cpu_stall, cpu_req);
            end
        end
        @(negedge clk);
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_req: mem_en got %b want 0", mem_en);
            end
        end
    endtask

    task automatic test_cpu_read();
        bit done_seen;
        int acc, stall_bad;
        @(negedge clk);
        mem_lat = 2;
        model[32'h100] = 32'hDEADBEEF;
        exp_acc.push_back('{is_ext: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_wdata = 0;
        #1;
        n_tests++;
        if (cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL read_stall_comb: got %b want 1", cpu_stall);
        end
        done_seen = 0; acc = 0; stall_bad = 0;
        for (int i = 0; i < 50 && !done_seen; i++) begin
            @(negedge clk);
            if (cpu_done) done_seen = 1;
            else begin
                if (mem_en) acc++;
                if (cpu_stall !== 1'b1) stall_bad++;
            end
        end
        n_tests++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL read_done: no cpu_done within 50 cycles");
        end
        n_tests++;
        if (stall_bad != 0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL read_stall: got %0d low cycles, stall at done=%b, want 0 and 0", stall_bad, cpu_stall);
        end
        n_tests++;
        if (acc != 3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_access_len: got %0d cycles err=%b, want 3 cycles err=0", acc, err);
        end
        cpu_req = 0;
        @(negedge clk);
        n_tests++;
        if (cpu_done !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_pulse_hold: got done=%b rdata=%h, want 0 deadbeef", cpu_done, cpu_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int cpu_at, ext_at;
        @(negedge clk);
        mem_lat = 0;
        model[32'h20] = 32'hA5A50020;
        exp_acc.push_back('{is_ext: 1'b0, we: 1'b1, addr: 32'h10, wdata: 32'h5});
        exp_acc.push_back('{is_ext: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
        exp_done.push_back('{is_ext: 1'b1, err: 1'b0, rdata: 32'hA5A50020});
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
        ext_req = 1; ext_we = 0; ext_addr = 32'h20; ext_wdata = 0;
        cpu_at = -1; ext_at = -1;
        for (int i = 0; i < 60 && (cpu_req || ext_req); i++) begin
            @(negedge clk);
            if (cpu_done) begin cpu_at = cyc; cpu_req = 0; end
            if (ext_done) begin ext_at = cyc; ext_req = 0; end
        end
        n_tests++;
        if (cpu_at < 0 || ext_at < 0 || ext_at <= cpu_at) begin
            n_fail++;
            $display("FAIL simul_order: got cpu_done@%0d ext_done@%0d, want cpu first", cpu_at, ext_at);
        end
        n_tests++;
        if (!model.exists(32'h10) || model[32'h10] !== 32'h5) begin
            n_fail++;
            $display("FAIL simul_write: memory[0x10] not written with 5");
        end
    endtask

    task automatic test_starvation();
        int n_cpu, cpu_before_ext, last, gap_bad;
        @(negedge clk);
        mem_lat = 0;
        model[32'h40] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            model[32'h80 + 4 * i] = 32'hC0000080 + 4 * i;
            exp_acc.push_back('{is_ext: 1'b0, we: 1'b0, addr: 32'h80 + 4 * i, wdata: 32'h0});
            exp_done.push_back('{is_ext: 1'b0, err: 1'b0, rdata: 32'hC0000080 + 4 * i});
        end
        exp_acc.push_back('{is_ext: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b1, err: 1'b0, rdata: 32'h12345678});
        model[32'h90] = 32'hC0000090;
        exp_acc.push_back('{is_ext: 1'b0, we: 1'b0, addr: 32'h90, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b0, err: 1'b0, rdata: 32'hC0000090});
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        ext_req = 1; ext_we = 0; ext_addr = 32'h40;
        n_cpu = 0; cpu_before_ext = -1; last = -1; gap_bad = 0;
        for (int i = 0; i < 200 && (cpu_req || ext_req); i++) begin
            @(negedge clk);
            if (cpu_done || ext_done) begin
                if (last >= 0 && cyc - last != 3) gap_bad++;
                last = cyc;
            end
            if (cpu_done) begin
                n_cpu++;
                if (n_cpu < 5) cpu_addr = 32'h80 + 4 * n_cpu;
                else cpu_req = 0;
            end
            if (ext_done) begin
                cpu_before_ext = n_cpu;
                ext_req = 0;
            end
        end
        n_tests++;
        if (cpu_before_ext != 4) begin
            n_fail++;
            $display("FAIL starve_streak: got %0d cpu grants before ext, want 4", cpu_before_ext);
        end
        n_tests++;
        if (n_cpu != 5) begin
            n_fail++;
            $display("FAIL starve_resume: got %0d cpu completions, want 5", n_cpu);
        end
        n_tests++;
        if (gap_bad != 0) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d done gaps not equal 3 cycles, want 0", gap_bad);
        end
    endtask

    task automatic test_timeout();
        bit started, done_seen;
        int idx, err_bad;
        @(negedge clk);
        mem_stuck = 1;
        model[32'h44] = 32'h0BAD0044;
        exp_acc.push_back('{is_ext: 1'b1, we: 1'b0, addr: 32'h44, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b1, err: 1'b1, rdata: 32'h0});
        ext_req = 1; ext_we = 0; ext_addr = 32'h44;
        started = 0; done_seen = 0; idx = 0; err_bad = 0;
        for (int i = 0; i < 60 && !done_seen; i++) begin
            @(negedge clk);
            if (mem_en) begin
                started = 1;
                idx++;
                if (err !== 1'b0) err_bad++;
            end else if (started) begin
                idx++;
                if (ext_done) done_seen = 1;
            end
        end
        n_tests++;
        if (!done_seen || idx != 17) begin
            n_fail++;
            $display("FAIL timeout_latency: got done=%b at cycle %0d of access, want 1 at 17", done_seen, idx);
        end
        n_tests++;
        if (err !== 1'b1 || ext_rdata !== 32'h0 || err_bad != 0) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b rdata=%h early_err=%0d, want 1 0 0", err, ext_rdata, err_bad);
        end
        ext_req = 0;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0 || ext_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b done=%b, want 0 0", err, ext_done);
        end
        mem_stuck = 0;
    endtask

    task automatic test_reset_mid();
        bit seen, done_seen, early_done;
        @(negedge clk);
        mem_lat = 3;
        model[32'h60] = 32'hCAFEF00D;
        exp_acc.push_back('{is_ext: 1'b0, we: 1'b0, addr: 32'h60, wdata: 32'h0});
        exp_acc.push_back('{is_ext: 1'b0, we: 1'b0, addr: 32'h60, wdata: 32'h0});
        exp_done.push_back('{is_ext: 1'b0, err: 1'b0, rdata: 32'hCAFEF00D});
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_en) seen = 1;
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (!seen || mem_en !== 1'b0 || cpu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got seen=%b mem_en=%b done=%b, want 1 0 0", seen, mem_en, cpu_done);
        end
        early_done = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (cpu_done !== 1'b0 || mem_en !== 1'b0) early_done = 1;
        end
        n_tests++;
        if (early_done) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got done or mem_en during reset, want none");
        end
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 50 && !done_seen; i++) begin
            @(negedge clk);
            if (cpu_done) done_seen = 1;
        end
        n_tests++;
        if (!done_seen || cpu_rdata !== 32'hCAFEF00D || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got done=%b rdata=%h err=%b, want 1 cafef00d 0",
                     done_seen, cpu_rdata, err);
        end
        cpu_req = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        mem_lat = 0; mem_stuck = 0;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;

        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();

        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_acc.size() != 0 || exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d grants and %0d completions outstanding, want 0 0",
                     exp_acc.size(), exp_done.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory between the multicycle CPU port and an external loader/debug port.
- Sequences each access as request, memory handshake and one-cycle completion.
- Drives a stall to the CPU path controller while its access is outstanding.
- Bounds CPU priority with an anti-starvation counter.
- Bounds memory waits with a timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_STREAK, 4, consecutive CPU grants allowed while ext_req waits before ext wins.
- TIMEOUT, 16, cycles in ACCESS without mem_ready before the access is aborted.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level, held until cpu_done.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU byte address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, valid when cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  cpu_req & ~cpu_done; gates PC/IR enables.
- ext_req  in  1  external request, level, held until ext_done.
- ext_we  in  1  external write enable.
- ext_addr  in  AW  external address.
- ext_wdata  in  DW  external write data.
- ext_rdata  out  DW  external read data, valid when ext_done=1.
- ext_done  out  1  one-cycle completion pulse to external port.
- err  out  1  completing access timed out; valid with the done pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, may be high in the first ACCESS cycle.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, streak=0, wait counter=0, owner=CPU.
  - All outputs 0: rdata regs, done, err, mem_* outputs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If cpu_req|ext_req: choose winner; latch owner, we, addr, wdata from winner; go ACCESS.
  - Otherwise stay IDLE.
- Winner rule:
  - Only one request present: that requester wins.
  - Both present: CPU wins unless streak==MAX_STREAK, in which case ext wins.
- streak counter:
  - +1 on a CPU grant while ext_req=1, saturating at MAX_STREAK.
  - Cleared on any ext grant, and in any IDLE cycle with ext_req=0.
- ACCESS:
  - mem_en=1; mem_we/addr/wdata come from latched registers and are stable for the whole state.
  - Wait counter increments every cycle.
  - mem_ready=1: capture mem_rdata into the owner's rdata register (writes capture nothing; rdata holds its previous value); err=0; go RESP.
  - Counter reaches TIMEOUT-1 without mem_ready: owner rdata=0, err=1, go RESP.
  - mem_ready wins over timeout when both occur in the same cycle.
- RESP:
  - mem_en=0; owner done=1 for exactly this cycle; err held from ACCESS.
  - Clear wait counter; go IDLE.
- Requester obligations:
  - Keep req and operands stable until done.
  - In the cycle after done, drop req or present the next request.
  - The arbiter never samples req in RESP, so no double grant occurs.
- Throughput: minimum 3 cycles per access (IDLE, ACCESS, RESP) with mem_ready in the first ACCESS cycle.
- Latency: done fires N+1 cycles after the grant edge, where N = number of ACCESS cycles.
- Request dropped mid-access: the access completes anyway and done still pulses; this is a protocol violation with no other effect.
- err clears to 0 in IDLE.
- rdata registers hold their value until that owner's next read completes.
- cpu_stall is combinational, with no registered delay.
- Reset asserted mid-ACCESS: immediate return to IDLE, mem_en=0, no done pulse; an in-flight write may or may not have taken effect.

Test Plan:
- Reset check: hold reset_n=0 with random inputs -> all outputs 0. Release with no requests -> mem_en stays 0.
- CPU read, mem_ready 2 cycles after mem_en rises, mem_rdata=0xDEADBEEF:
  - cpu_rdata=0xDEADBEEF, cpu_done pulses 1 cycle, err=0.
  - cpu_stall high from req until the done cycle.
- Simultaneous cpu_req (write 0x10←0x5) and ext_req (read 0x20):
  - CPU served first; mem_addr=0x10, mem_we=1.
  - Then ext served, mem_addr=0x20, ext_done pulses after cpu_done.
- Starvation: CPU re-requests every cycle after done; ext_req held high; MAX_STREAK=4:
  - Exactly 4 cpu_done pulses, then ext granted, then CPU resumes.
- Timeout: mem_ready tied 0, TIMEOUT=16, ext read:
  - ext_done pulses 17 cycles after the grant, with err=1 and ext_rdata=0.
- Reset mid-access: assert reset_n=0 during ACCESS of a CPU read:
  - mem_en drops asynchronously; no cpu_done.
  - After release with cpu_req still high, the access restarts and completes normally.
